// File: rtl/spi_slave_ctrl_if.sv
// Command/read-data bundle between the SPI pins, the slave controller and the data memory.
interface spi_slave_ctrl_if #(
  parameter int unsigned CMD_W  = 10,
  parameter int unsigned DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [CMD_W-1:0]  rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises command words from MOSI and serialises read bytes onto MISO.
module spi_slave_ctrl #(
  parameter int unsigned CMD_W  = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StChkCmd, StWrite, StReadAdd, StReadData} state_e;

  localparam int unsigned CntW = $clog2(CMD_W + DATA_W + 2);
  // Counter walks: receive (0..LastRx), wait, load, shift-out, then parks past LastTx.
  localparam logic [CntW-1:0] LastRx  = CntW'(CMD_W - 2);
  localparam logic [CntW-1:0] RxDone  = CntW'(CMD_W - 1);
  localparam logic [CntW-1:0] LoadCnt = CntW'(CMD_W);
  localparam logic [CntW-1:0] LastTx  = CntW'(CMD_W + DATA_W);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CMD_W-2:0]    rx_shift_q, rx_shift_d;
  logic [CMD_W-1:0]    rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic                miso_q, miso_d;
  logic                addr_rcvd_q, addr_rcvd_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    miso_d      = 1'b0;
    addr_rcvd_d = addr_rcvd_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!bus.SS_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        rx_shift_d = {(CMD_W-2)'(0), bus.MOSI};
        cnt_d      = '0;
        if (!bus.MOSI)        state_d = StWrite;
        else if (addr_rcvd_q) state_d = StReadData;
        else                  state_d = StReadAdd;
      end
      default: begin
        if (cnt_q < RxDone) begin
          rx_shift_d = {rx_shift_q[CMD_W-3:0], bus.MOSI};
          cnt_d      = cnt_q + CntW'(1);
          if (cnt_q == LastRx) begin
            rx_data_d  = {rx_shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            if (state_q == StReadAdd) addr_rcvd_d = 1'b1;
          end
        end else if (state_q == StReadData) begin
          if (cnt_q == RxDone) begin
            cnt_d = cnt_q + CntW'(1);
          end else if (cnt_q == LoadCnt) begin
            // Stall here until the memory presents a valid byte.
            if (bus.tx_valid) begin
              tx_shift_d = bus.tx_data;
              cnt_d      = cnt_q + CntW'(1);
            end
          end else if (cnt_q <= LastTx) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            cnt_d      = cnt_q + CntW'(1);
            if (cnt_q == LastTx) addr_rcvd_d = 1'b0;
          end
        end
      end
    endcase

    // Deselect aborts the frame; addr_rcvd and rx_data are deliberately kept.
    if (state_q != StIdle && bus.SS_n) begin
      state_d     = StIdle;
      cnt_d       = '0;
      miso_d      = 1'b0;
      rx_valid_d  = 1'b0;
      rx_data_d   = rx_data_q;
      addr_rcvd_d = addr_rcvd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      addr_rcvd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      addr_rcvd_q <= addr_rcvd_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised self-checking bench for spi_slave_ctrl against a frame-level reference model.
module tb_spi_slave_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_ctrl_if #(.CMD_W(10), .DATA_W(8)) bus ();

  spi_slave_ctrl #(.CMD_W(10), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame-level state only.
  logic       addr_rcvd_m = 1'b0;
  logic [9:0] rx_data_m   = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI frame. abort_bits: deselect after that many MOSI bits (-1 = none).
  // abort_miso / rst_miso: deselect / reset after that many MISO bits (-1 = none).
  task automatic do_frame(input logic [9:0] word, input logic [7:0] txd, input int txv_delay,
                          input int abort_bits, input int abort_miso, input int rst_miso);
    bit rd;
    rd = word[9] && addr_rcvd_m;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    tick();
    for (int i = 9; i >= 0; i--) begin
      if (abort_bits == 9 - i) begin
        bus.SS_n = 1'b1;
        tick();
        vectors++;
        if (bus.rx_valid !== 1'b0 || bus.rx_data !== rx_data_m || bus.MISO !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_rx: got rv=%b data=%h miso=%b want rv=0 data=%h miso=0",
                   bus.rx_valid, bus.rx_data, bus.MISO, rx_data_m);
        end
        return;
      end
      bus.MOSI     = word[i];
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
      tick();
      if (i == 0) rx_data_m = word;
      vectors++;
      if (bus.rx_valid !== (i == 0) || bus.rx_data !== rx_data_m || bus.MISO !== 1'b0) begin
        miscompares++;
        $display("FAIL rx_bit%0d: got rv=%b data=%h miso=%b want rv=%b data=%h miso=0",
                 i, bus.rx_valid, bus.rx_data, bus.MISO, (i == 0), rx_data_m);
      end
    end
    if (word[9] && !addr_rcvd_m) addr_rcvd_m = 1'b1;
    bus.MOSI     = 1'($urandom);
    bus.tx_valid = 1'b0;
    tick();
    vectors++;
    if (bus.rx_valid !== 1'b0 || bus.MISO !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rx: got rv=%b miso=%b want rv=0 miso=0", bus.rx_valid, bus.MISO);
    end
    if (rd) begin
      for (int d = 0; d < txv_delay; d++) begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        tick();
        vectors++;
        if (bus.MISO !== 1'b0) begin
          miscompares++;
          $display("FAIL tx_stall: got miso=%b want 0", bus.MISO);
        end
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = txd;
      tick();
      vectors++;
      if (bus.MISO !== 1'b0) begin
        miscompares++;
        $display("FAIL tx_load: got miso=%b want 0", bus.MISO);
      end
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        bus.MOSI = 1'($urandom);
        tick();
        vectors++;
        if (bus.MISO !== txd[7-k] || bus.rx_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL miso_bit%0d: got miso=%b rv=%b want miso=%b rv=0",
                   7 - k, bus.MISO, bus.rx_valid, txd[7-k]);
        end
        if (k + 1 == abort_miso) begin
          bus.SS_n = 1'b1;
          tick();
          vectors++;
          if (bus.MISO !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_miso: got miso=%b want 0", bus.MISO);
          end
          return;
        end
        if (k + 1 == rst_miso) begin
          rst = 1'b1;
          tick();
          addr_rcvd_m = 1'b0;
          rx_data_m   = '0;
          vectors++;
          if (bus.MISO !== 1'b0 || bus.rx_data !== 10'h000 || bus.rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_read: got miso=%b data=%h rv=%b want 0 000 0",
                     bus.MISO, bus.rx_data, bus.rx_valid);
          end
          rst      = 1'b0;
          bus.SS_n = 1'b1;
          tick();
          return;
        end
      end
      addr_rcvd_m = 1'b0;
    end else begin
      // Valid memory data must not leak onto MISO outside a read-data frame.
      bus.tx_valid = 1'b1;
      for (int h = 0; h < 12; h++) begin
        bus.tx_data = 8'($urandom);
        bus.MOSI    = 1'($urandom);
        tick();
        vectors++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_quiet: got miso=%b rv=%b want 0 0", bus.MISO, bus.rx_valid);
        end
      end
      bus.tx_valid = 1'b0;
    end
    repeat (2) begin
      tick();
      vectors++;
      if (bus.MISO !== 1'b0) begin
        miscompares++;
        $display("FAIL tail_miso: got miso=%b want 0", bus.MISO);
      end
    end
    bus.SS_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.SS_n = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    for (int i = 0; i < 2; i++) begin
      bus.MOSI = 1'(i);
      tick();
      vectors++;
      if (bus.rx_data !== 10'h000 || bus.rx_valid !== 1'b0 || bus.MISO !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: got data=%h rv=%b miso=%b want 000 0 0",
                 bus.rx_data, bus.rx_valid, bus.MISO);
      end
    end
    rst = 1'b0;
    bus.SS_n = 1'b1;
    addr_rcvd_m = 1'b0;
    rx_data_m = '0;
    // MOSI activity while deselected must be ignored.
    for (int i = 0; i < 4; i++) begin
      bus.MOSI = 1'($urandom);
      tick();
      vectors++;
      if (bus.rx_valid !== 1'b0 || bus.rx_data !== 10'h000 || bus.MISO !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet: got rv=%b data=%h miso=%b want 0 000 0",
                 bus.rx_valid, bus.rx_data, bus.MISO);
      end
    end
  endtask

  task automatic test_write_addr();
    do_frame(10'b00_1010_0101, 8'h00, 0, -1, -1, -1);
    vectors++;
    if (bus.rx_data !== 10'h0A5) begin
      miscompares++;
      $display("FAIL write_addr: got %h want 0a5", bus.rx_data);
    end
  endtask

  task automatic test_write_data();
    do_frame(10'b01_0011_1100, 8'h00, 0, -1, -1, -1);
    vectors++;
    if (bus.rx_data !== 10'h13C) begin
      miscompares++;
      $display("FAIL write_data: got %h want 13c", bus.rx_data);
    end
  endtask

  task automatic test_read_seq();
    do_frame(10'b10_0000_0111, 8'h00, 0, -1, -1, -1);
    vectors++;
    if (bus.rx_data !== 10'h207) begin
      miscompares++;
      $display("FAIL read_addr: got %h want 207", bus.rx_data);
    end
    do_frame({2'b11, 8'($urandom)}, 8'hC3, 0, -1, -1, -1);
    // addr_rcvd cleared: this one is a read-address frame, then a stalled read.
    do_frame({2'b10, 8'($urandom)}, 8'h00, 0, -1, -1, -1);
    do_frame({2'b11, 8'($urandom)}, 8'($urandom), 3, -1, -1, -1);
  endtask

  task automatic test_abort();
    do_frame(10'h13C, 8'h00, 0, -1, -1, -1);
    do_frame(10'($urandom), 8'h00, 0, 5, -1, -1);
    vectors++;
    if (bus.rx_data !== 10'h13C) begin
      miscompares++;
      $display("FAIL abort_keep: got %h want 13c", bus.rx_data);
    end
    do_frame(10'($urandom), 8'($urandom), 1, -1, -1, -1);
    if (!addr_rcvd_m) do_frame({2'b10, 8'($urandom)}, 8'h00, 0, -1, -1, -1);
    do_frame({2'b11, 8'($urandom)}, 8'($urandom), 0, -1, 3, -1);
    do_frame({2'b11, 8'($urandom)}, 8'($urandom), 2, -1, -1, -1);
  endtask

  task automatic test_reset_mid_read();
    if (!addr_rcvd_m) do_frame({2'b10, 8'($urandom)}, 8'h00, 0, -1, -1, -1);
    do_frame({2'b11, 8'($urandom)}, 8'hA6, 0, -1, -1, 4);
    do_frame({2'b11, 8'($urandom)}, 8'hFF, 0, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int ab;
      int am;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      am = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : -1;
      do_frame(10'($urandom), 8'($urandom), int'($urandom_range(0, 3)), ab, am, -1);
    end
  endtask

  initial begin
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_seq();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
